// File: rtl/kronos_mem_arbiter_if.sv
// Bus bundle for the IF/LSU memory arbiter: the two core-side requesters plus the shared memory port.
// The arbiter uses the slave view; the core/memory environment uses the master view.
interface kronos_mem_arbiter_if;
  logic [31:0] instr_addr;
  logic        instr_req;
  logic        instr_gnt;
  logic [31:0] instr_data;

  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [3:0]  data_mask;
  logic        data_wr_en;
  logic        data_req;
  logic        data_gnt;
  logic [31:0] data_rdata;

  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_mask;
  logic        mem_wr_en;
  logic        mem_req;
  logic        mem_gnt;
  logic [31:0] mem_rdata;

  modport slave (
    input  instr_addr, instr_req,
    output instr_gnt, instr_data,
    input  data_addr, data_wdata, data_mask, data_wr_en, data_req,
    output data_gnt, data_rdata,
    output mem_addr, mem_wdata, mem_mask, mem_wr_en, mem_req,
    input  mem_gnt, mem_rdata
  );

  modport master (
    output instr_addr, instr_req,
    input  instr_gnt, instr_data,
    output data_addr, data_wdata, data_mask, data_wr_en, data_req,
    input  data_gnt, data_rdata,
    input  mem_addr, mem_wdata, mem_mask, mem_wr_en, mem_req,
    output mem_gnt, mem_rdata
  );
endinterface

// File: rtl/kronos_mem_arbiter.sv
// Shares one memory port between instruction fetch and load/store. LSU has fixed priority;
// a saturating streak counter forces IF to win after MAX_DATA_STREAK LSU grants while IF waits.
module kronos_mem_arbiter #(
  parameter int unsigned MAX_DATA_STREAK = 4
) (
  input logic                  clk,
  input logic                  rstz,
  kronos_mem_arbiter_if.slave  bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] OWN_I = 2'd1;
  localparam logic [1:0] OWN_D = 2'd2;

  localparam logic [7:0] STREAK_MAX = 8'(MAX_DATA_STREAK);

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic [7:0] streak;
  logic       sel_i;
  logic       sel_d;

  // Selection: owner while locked, otherwise the combinational winner. Gated by rstz so
  // the request drops in the same cycle reset asserts.
  always_comb begin
    sel_i = 1'b0;
    sel_d = 1'b0;
    case (state)
      IDLE: begin
        if (bus.data_req && (!bus.instr_req || streak < STREAK_MAX)) sel_d = 1'b1;
        else if (bus.instr_req)                                       sel_i = 1'b1;
      end
      OWN_I:   sel_i = bus.instr_req;
      OWN_D:   sel_d = bus.data_req;
      default: ;
    endcase
    if (!rstz) begin
      sel_i = 1'b0;
      sel_d = 1'b0;
    end
  end

  always_comb begin
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_mask  = '0;
    bus.mem_wr_en = 1'b0;
    bus.mem_req   = 1'b0;
    if (sel_d) begin
      bus.mem_addr  = bus.data_addr;
      bus.mem_wdata = bus.data_wdata;
      bus.mem_mask  = bus.data_mask;
      bus.mem_wr_en = bus.data_wr_en;
      bus.mem_req   = 1'b1;
    end else if (sel_i) begin
      bus.mem_addr  = bus.instr_addr;
      bus.mem_mask  = '1;
      bus.mem_req   = 1'b1;
    end
  end

  assign bus.instr_gnt  = bus.mem_gnt & sel_i;
  assign bus.data_gnt   = bus.mem_gnt & sel_d;
  assign bus.instr_data = bus.mem_rdata;
  assign bus.data_rdata = bus.mem_rdata;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (sel_d && !bus.mem_gnt)      state_nxt = OWN_D;
        else if (sel_i && !bus.mem_gnt) state_nxt = OWN_I;
      end
      // A withdrawn owner deselects itself, so no request and no grant go out on the way back.
      OWN_I, OWN_D: begin
        if (!(sel_i || sel_d) || bus.mem_gnt) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      state  <= IDLE;
      streak <= '0;
    end else begin
      state <= state_nxt;
      if (bus.data_gnt) begin
        if (!bus.instr_req)           streak <= '0;
        else if (streak < STREAK_MAX) streak <= streak + 8'd1;
      end else if (bus.instr_gnt) begin
        streak <= '0;
      end
    end
  end

endmodule

// File: tb/tb_kronos_mem_arbiter.sv
// Directed bench for kronos_mem_arbiter: arbitration order, stalls, muxing, withdrawal and reset.
module tb_kronos_mem_arbiter;

  logic clk;
  logic rstz;
  int unsigned n_checks;
  int unsigned n_errors;

  kronos_mem_arbiter_if bus ();

  kronos_mem_arbiter #(.MAX_DATA_STREAK(4)) dut (
    .clk  (clk),
    .rstz (rstz),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.instr_addr = '0;
    bus.instr_req  = 1'b0;
    bus.data_addr  = '0;
    bus.data_wdata = '0;
    bus.data_mask  = '0;
    bus.data_wr_en = 1'b0;
    bus.data_req   = 1'b0;
    bus.mem_gnt    = 1'b0;
    bus.mem_rdata  = '0;
  endtask

  logic [9:0] grant_d;

  initial begin
    n_checks = 0;
    n_errors = 0;
    idle_inputs();
    rstz = 1'b0;
    bus.instr_req = 1'b1;
    bus.mem_gnt   = 1'b1;
    #1;
    check("rst_mem_req",   32'(bus.mem_req),   32'd0);
    check("rst_instr_gnt", 32'(bus.instr_gnt), 32'd0);
    check("rst_data_gnt",  32'(bus.data_gnt),  32'd0);
    check("rst_state",     32'(dut.state),     32'd0);
    check("rst_streak",    32'(dut.streak),    32'd0);
    tick();
    idle_inputs();
    rstz = 1'b1;
    tick();

    // IF stream with memory always ready
    bus.instr_req  = 1'b1;
    bus.mem_gnt    = 1'b1;
    bus.data_wdata = 32'h1234_5678;
    for (int unsigned i = 0; i < 3; i++) begin
      bus.instr_addr = 32'(i * 4);
      bus.mem_rdata  = 32'hA000_0000 + 32'(i);
      #1;
      check("if_addr",  bus.mem_addr, 32'(i * 4));
      check("if_gnt",   32'(bus.instr_gnt), 32'd1);
      check("if_data",  bus.instr_data, 32'hA000_0000 + 32'(i));
      check("if_wr_en", 32'(bus.mem_wr_en), 32'd0);
      check("if_mask",  32'(bus.mem_mask), 32'hF);
      check("if_wdata", bus.mem_wdata, 32'd0);
      tick();
    end

    // Both requesting: D,D,D,D,I,D,D,D,D,I
    grant_d = 10'b1111011110;
    bus.data_req  = 1'b1;
    bus.data_addr = 32'h0000_0080;
    for (int unsigned i = 0; i < 10; i++) begin
      #1;
      check("order_dgnt", 32'(bus.data_gnt),  32'(grant_d[9 - i]));
      check("order_ignt", 32'(bus.instr_gnt), 32'(!grant_d[9 - i]));
      tick();
      if (!grant_d[9 - i]) check("order_streak_clr", 32'(dut.streak), 32'd0);
    end

    // LSU stalled for three cycles while IF waits
    idle_inputs();
    tick();
    bus.data_req   = 1'b1;
    bus.data_addr  = 32'h0000_0100;
    bus.instr_addr = 32'h0000_0040;
    #1;
    check("stall_c0_req",  32'(bus.mem_req),  32'd1);
    check("stall_c0_dgnt", 32'(bus.data_gnt), 32'd0);
    tick();
    bus.instr_req = 1'b1;
    for (int unsigned i = 1; i < 3; i++) begin
      #1;
      check("stall_state", 32'(dut.state),     32'd2);
      check("stall_addr",  bus.mem_addr,       32'h100);
      check("stall_ignt",  32'(bus.instr_gnt), 32'd0);
      tick();
    end
    bus.mem_gnt = 1'b1;
    #1;
    check("stall_c3_dgnt", 32'(bus.data_gnt),  32'd1);
    check("stall_c3_ignt", 32'(bus.instr_gnt), 32'd0);
    tick();
    bus.data_req = 1'b0;
    #1;
    check("stall_streak", 32'(dut.streak),     32'd1);
    check("stall_if_gnt", 32'(bus.instr_gnt),  32'd1);
    check("stall_if_adr", bus.mem_addr,        32'h40);
    tick();

    // LSU write, then IF grant muxing
    idle_inputs();
    bus.data_req   = 1'b1;
    bus.data_wr_en = 1'b1;
    bus.data_mask  = 4'b0011;
    bus.data_wdata = 32'hDEAD_BEEF;
    bus.data_addr  = 32'h0000_0200;
    bus.mem_gnt    = 1'b1;
    #1;
    check("wr_gnt",   32'(bus.data_gnt),  32'd1);
    check("wr_addr",  bus.mem_addr,       32'h200);
    check("wr_wr_en", 32'(bus.mem_wr_en), 32'd1);
    check("wr_mask",  32'(bus.mem_mask),  32'h3);
    check("wr_wdata", bus.mem_wdata,      32'hDEAD_BEEF);
    tick();
    bus.data_req   = 1'b0;
    bus.instr_req  = 1'b1;
    bus.instr_addr = 32'h0000_0300;
    #1;
    check("wr_if_gnt",   32'(bus.instr_gnt), 32'd1);
    check("wr_if_wr_en", 32'(bus.mem_wr_en), 32'd0);
    check("wr_if_mask",  32'(bus.mem_mask),  32'hF);
    check("wr_if_wdata", bus.mem_wdata,      32'd0);
    tick();

    // IF owner withdraws; pending LSU waits a cycle
    idle_inputs();
    bus.instr_req  = 1'b1;
    bus.instr_addr = 32'h0000_0500;
    tick();
    check("wd_state_owni", 32'(dut.state), 32'd1);
    bus.instr_req = 1'b0;
    bus.data_req  = 1'b1;
    bus.data_addr = 32'h0000_0600;
    bus.mem_gnt   = 1'b1;
    #1;
    check("wd_mem_req", 32'(bus.mem_req),   32'd0);
    check("wd_ignt",    32'(bus.instr_gnt), 32'd0);
    check("wd_dgnt",    32'(bus.data_gnt),  32'd0);
    tick();
    check("wd_state_idle", 32'(dut.state),    32'd0);
    check("wd_next_dgnt",  32'(bus.data_gnt), 32'd1);
    check("wd_next_addr",  bus.mem_addr,      32'h600);
    tick();

    // Reset pulsed during OWN_D with a nonzero streak
    idle_inputs();
    bus.instr_req = 1'b1;
    bus.data_req  = 1'b1;
    bus.data_addr = 32'h0000_0700;
    bus.mem_gnt   = 1'b1;
    tick();
    bus.instr_req = 1'b0;
    bus.mem_gnt   = 1'b0;
    tick();
    check("rd_state_ownd", 32'(dut.state),  32'd2);
    check("rd_streak",     32'(dut.streak), 32'd1);
    bus.mem_gnt = 1'b1;
    rstz = 1'b0;
    #1;
    check("rd_mem_req", 32'(bus.mem_req),  32'd0);
    check("rd_dgnt",    32'(bus.data_gnt), 32'd0);
    check("rd_state",   32'(dut.state),    32'd0);
    check("rd_streak0", 32'(dut.streak),   32'd0);
    tick();
    rstz = 1'b1;
    #1;
    check("rd_resume_dgnt", 32'(bus.data_gnt), 32'd1);
    check("rd_resume_addr", bus.mem_addr,      32'h700);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/kronos_mem_arbiter.md
Name: kronos_mem_arbiter

Overview:
- Shares a single memory port between instruction fetch (IF) and load/store (LSU) requesters.
- Both sides use the core's req/gnt handshake. A transfer completes in the cycle where req and gnt are both high; read data is valid in that same cycle.
- The LSU has fixed priority. A bounded-streak counter prevents fetch starvation.
- Sits between the core (IF, LSU) and the single-port memory or bus bridge.

Parameters:
- MAX_DATA_STREAK, 4: consecutive LSU grants allowed while IF is waiting before IF is forced to win. Legal range is 1..255.

Ports:
- clk  in  1  clock.
- rstz  in  1  asynchronous active-low reset.
- instr_addr  in  32  IF request address.
- instr_req  in  1  IF request.
- instr_gnt  out  1  IF transfer complete.
- instr_data  out  32  IF read data.
- data_addr  in  32  LSU address.
- data_wdata  in  32  LSU write data.
- data_mask  in  4  LSU byte enables.
- data_wr_en  in  1  LSU write (1) or read (0).
- data_req  in  1  LSU request.
- data_gnt  out  1  LSU transfer complete.
- data_rdata  out  32  LSU read data.
- mem_addr  out  32  memory address.
- mem_wdata  out  32  memory write data.
- mem_mask  out  4  memory byte enables.
- mem_wr_en  out  1  memory write enable.
- mem_req  out  1  memory request.
- mem_gnt  in  1  memory transfer complete.
- mem_rdata  in  32  memory read data.

Behaviour:
- Reset (asynchronous, any time, including mid-transfer):
  - state=IDLE, streak=0.
  - mem_req, instr_gnt and data_gnt are 0 while rstz is low. mem_req drops in the same cycle reset asserts.
  - The memory side must tolerate abandoned requests.
- States:
  - IDLE: no owner.
  - OWN_I: port locked to IF.
  - OWN_D: port locked to LSU.
- Mux source:
  - Selected source is the owner in OWN_x, or the arbitration winner in IDLE.
  - mem_addr, mem_wdata, mem_mask, mem_wr_en and mem_req come from the selected source.
  - When IF is selected: mem_wr_en=0, mem_mask=4'hF, mem_wdata=0.
  - When nothing is selected: mem_req=0 and the other outputs are don't-care, driven 0.
- Arbitration (IDLE only, combinational, zero added latency):
  - Only data_req: winner is LSU.
  - Only instr_req: winner is IF.
  - Both high and streak<MAX_DATA_STREAK: winner is LSU.
  - Both high and streak==MAX_DATA_STREAK: winner is IF.
- Grant routing:
  - instr_gnt = mem_gnt & (selected==IF).
  - data_gnt = mem_gnt & (selected==LSU).
  - The non-selected gnt is always 0.
  - instr_data and data_rdata both equal mem_rdata; they are only meaningful with the corresponding gnt.
- Transitions:
  - IDLE, winner x, mem_gnt=1: transfer done in the same cycle; stay IDLE.
  - IDLE, winner x, mem_gnt=0: go to OWN_x.
  - OWN_x, x_req=1, mem_gnt=1: go to IDLE. The next arbitration happens the following cycle.
  - OWN_x, x_req=0 (requester withdrew, e.g. IF flush): mem_req=0 this cycle; go to IDLE; no gnt issued.
  - OWN_x ignores the other requester entirely. No preemption.
- Request stability: the owner's address and control may change while it is owner (IF redirect). The arbiter forwards them unchanged; request-stability rules belong to the memory.
- Streak counter (8 bits, saturating at MAX_DATA_STREAK), updated on a completed LSU transfer:
  - If instr_req is high that cycle: streak += 1.
  - Otherwise: streak = 0.
- On a completed IF transfer: streak = 0.
- Throughput: back-to-back single-cycle grants to the same or alternating requesters, with no idle bubble, are allowed only for same-cycle-gnt completions from IDLE.

Test Plan:
- Reset, then instr_req=1 at instr_addr=0x0 with mem_gnt tied high → mem_addr=0x0, instr_gnt=1 the same cycle, instr_data=mem_rdata. A PC stream 0x0,0x4,0x8 completes one per cycle.
- Both requests high, MAX_DATA_STREAK=4, mem_gnt=1 every cycle → grant order D,D,D,D,I,D,D,D,D,I; streak resets to 0 after each IF grant.
- data_req read at 0x100, mem_gnt low for 3 cycles, instr_req raised in cycle 1 → state OWN_D, mem_addr stays 0x100, instr_gnt=0. data_gnt=1 in cycle 3, then IF is served.
- LSU write 0xDEADBEEF, mask 4'b0011, to 0x200 → mem_wr_en=1, mem_mask=4'b0011, mem_wdata=0xDEADBEEF. During an IF grant, mem_wr_en=0 and mem_mask=4'hF.
- IF owner with mem_gnt=0, then instr_req drops → mem_req=0 that cycle, state returns to IDLE, no instr_gnt. A pending data_req is granted on the next cycle.
- rstz pulsed low during OWN_D → mem_req=0 and data_gnt=0 immediately; after release, state=IDLE, streak=0, and normal arbitration resumes.
